// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and the bit-count width helper for the SIPO block
package sipo_pkg;
    localparam int SIPO_DEFAULT_WIDTH = 4;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/sipo.sv
// sipo: serial-in parallel-out shift register with a one-cycle word-boundary pulse
module sipo
    import sipo_pkg::*;
#(
    parameter int WIDTH  = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_IN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        si,
    output logic [WIDTH-1:0]            q,
    output logic                        word_valid,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d;
    always_comb begin
        q_d   = MSB_IN ? {q_q[WIDTH-2:0], si} : {si, q_q[WIDTH-1:1]};
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        vld_d = (cnt_q == LAST);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end
    assign q          = q_q;
    assign bit_cnt    = cnt_q;
    assign word_valid = vld_q;
endmodule

// File: tb/tb_sipo.sv
// tb_sipo: table-driven, hand-sequenced and randomized checks of sipo against a bit-history model
module tb_sipo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic si  = 1'b0;
    logic [3:0] q4, q4l;
    logic [7:0] q8;
    logic       v4, v4l, v8;
    logic [2:0] c4, c4l;
    logic [3:0] c8;
    int         n_pass = 0;
    int         n_tot  = 0;
    logic       hist[$];
    int         n_since_rst = 0;

    always #5 clk = ~clk;

    sipo #(.WIDTH(4), .MSB_IN(1'b1)) u4  (.clk(clk), .rst(rst), .si(si), .q(q4),  .word_valid(v4),  .bit_cnt(c4));
    sipo #(.WIDTH(4), .MSB_IN(1'b0)) u4l (.clk(clk), .rst(rst), .si(si), .q(q4l), .word_valid(v4l), .bit_cnt(c4l));
    sipo #(.WIDTH(8), .MSB_IN(1'b1)) u8  (.clk(clk), .rst(rst), .si(si), .q(q8),  .word_valid(v8),  .bit_cnt(c8));

    typedef struct {
        logic       r;
        logic       b;
        logic [3:0] q_msb;
        logic [3:0] q_lsb;
        logic       v;
        logic [2:0] c;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst = r;
        si  = b;
        @(posedge clk);
        if (r) begin
            hist.delete();
            n_since_rst = 0;
        end else begin
            hist.push_front(b);
            n_since_rst++;
            if (hist.size() > 64) void'(hist.pop_back());
        end
        #1;
    endtask

    function automatic logic [7:0] exp_q(input int w, input bit msb);
        logic [7:0] e = '0;
        for (int i = 0; i < w; i++) begin
            logic b = (i < hist.size()) ? hist[i] : 1'b0;
            if (msb) e[i] = b;
            else e[w-1-i] = b;
        end
        return e;
    endfunction

    task automatic chk_model();
        chk("m4_q",   64'(q4),  64'(exp_q(4, 1'b1)));
        chk("m4l_q",  64'(q4l), 64'(exp_q(4, 1'b0)));
        chk("m8_q",   64'(q8),  64'(exp_q(8, 1'b1)));
        chk("m4_cnt", 64'(c4),  64'(n_since_rst % 4));
        chk("m4l_cnt",64'(c4l), 64'(n_since_rst % 4));
        chk("m8_cnt", 64'(c8),  64'(n_since_rst % 8));
        chk("m4_vld", 64'(v4),  64'(n_since_rst > 0 && n_since_rst % 4 == 0));
        chk("m4l_vld",64'(v4l), 64'(n_since_rst > 0 && n_since_rst % 4 == 0));
        chk("m8_vld", 64'(v8),  64'(n_since_rst > 0 && n_since_rst % 8 == 0));
    endtask

    initial begin
        vec_t tbl[19];
        logic [11:0] s;
        tbl = '{
            '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0},
            '{1'b0, 1'b1, 4'b0001, 4'b1000, 1'b0, 3'd1},
            '{1'b0, 1'b0, 4'b0010, 4'b0100, 1'b0, 3'd2},
            '{1'b0, 1'b0, 4'b0100, 4'b0010, 1'b0, 3'd3},
            '{1'b0, 1'b1, 4'b1001, 4'b1001, 1'b1, 3'd0},
            '{1'b0, 1'b1, 4'b0011, 4'b1100, 1'b0, 3'd1},
            '{1'b0, 1'b1, 4'b0111, 4'b1110, 1'b0, 3'd2},
            '{1'b0, 1'b0, 4'b1110, 4'b0111, 1'b0, 3'd3},
            '{1'b0, 1'b0, 4'b1100, 4'b0011, 1'b1, 3'd0},
            '{1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0, 3'd1},
            '{1'b0, 1'b0, 4'b0010, 4'b0100, 1'b0, 3'd2},
            '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0},
            '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0},
            '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0},
            '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd1},
            '{1'b0, 1'b1, 4'b0001, 4'b1000, 1'b0, 3'd2},
            '{1'b0, 1'b1, 4'b0011, 4'b1100, 1'b0, 3'd3},
            '{1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 3'd0},
            '{1'b0, 1'b0, 4'b1100, 4'b0011, 1'b0, 3'd1}
        };
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r, tbl[i].b);
            chk($sformatf("tbl%0d_q_msb", i), 64'(q4),  64'(tbl[i].q_msb));
            chk($sformatf("tbl%0d_q_lsb", i), 64'(q4l), 64'(tbl[i].q_lsb));
            chk($sformatf("tbl%0d_vld", i),   64'(v4),  64'(tbl[i].v));
            chk($sformatf("tbl%0d_cnt", i),   64'(c4),  64'(tbl[i].c));
        end

        s = 12'($urandom);
        step(1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, s[12-k]);
            chk($sformatf("grp_vld%0d", k), 64'(v4), 64'(k % 4 == 0));
            if (k % 4 == 0) chk($sformatf("grp_q%0d", k), 64'(q4), 64'(s[15-k -: 4]));
        end

        step(1'b1, 1'b1);
        chk_model();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 49) == 0, 1'($urandom));
            chk_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
